// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the phase sequencer: FSM state encoding and default widths.
package phase_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int CW_DEFAULT = 8;

endpackage

// File: rtl/phase_sequencer_counter.sv
// In-phase counter: counts up to a terminal compare value, flags the terminal
// cycle and wraps to zero on that cycle when enabled.
module phase_counter
    import phase_sequencer_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] cmp,
    output logic [CW-1:0] count,
    output logic          tick
);

    assign tick = (count == cmp);

    // Count up while enabled; terminal cycle returns to zero, so count never passes cmp.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (en) begin
            if (tick) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Multi-phase timer controller: steps an in-phase counter through a small table
// of (duration, level) entries and drives a registered waveform from it.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int NPHASE = 4,
    parameter int AW     = 2,
    parameter int CW     = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [CW-1:0] cfg_dur,
    input  logic          cfg_lvl,
    input  logic [AW-1:0] last_phase,
    input  logic          loop_en,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic [AW-1:0] phase_idx,
    output logic [CW-1:0] count,
    output logic          out_level,
    output logic          phase_tick,
    output logic          done
);

    state_t        state;
    logic [CW-1:0] dur_tbl [NPHASE];
    logic          lvl_tbl [NPHASE];
    logic [AW-1:0] last_s;
    logic          loop_s;
    logic          cnt_tick;
    logic          cnt_clr;
    logic          cnt_en;
    logic [AW-1:0] next_idx;

    assign busy       = (state == ST_RUN);
    assign phase_tick = busy && cnt_tick;
    assign next_idx   = phase_idx + AW'(1);

    // Counter only runs in RUN; it is held at zero everywhere else and on abort.
    assign cnt_en  = busy;
    assign cnt_clr = clr || abort || !busy;

    phase_counter #(
        .CW (CW)
    ) u_counter (
        .clk   (clk),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cmp   (dur_tbl[phase_idx]),
        .count (count),
        .tick  (cnt_tick)
    );

    // Sequencer FSM with table, sampled run options and registered outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= ST_IDLE;
            phase_idx <= '0;
            out_level <= 1'b0;
            done      <= 1'b0;
            last_s    <= '0;
            loop_s    <= 1'b0;
            for (int i = 0; i < NPHASE; i++) begin
                dur_tbl[i] <= '0;
                lvl_tbl[i] <= 1'b0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    out_level <= 1'b0;
                    if (cfg_we) begin
                        dur_tbl[cfg_addr] <= cfg_dur;
                        lvl_tbl[cfg_addr] <= cfg_lvl;
                    end
                    // abort has priority over a simultaneous start
                    if (start && !abort) begin
                        state     <= ST_RUN;
                        last_s    <= last_phase;
                        loop_s    <= loop_en;
                        phase_idx <= '0;
                        out_level <= lvl_tbl[0];
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        phase_idx <= '0;
                        out_level <= 1'b0;
                    end else if (!cnt_tick) begin
                        out_level <= lvl_tbl[phase_idx];
                    end else if (phase_idx != last_s) begin
                        phase_idx <= next_idx;
                        out_level <= lvl_tbl[next_idx];
                    end else if (loop_s) begin
                        phase_idx <= '0;
                        out_level <= lvl_tbl[0];
                    end else begin
                        state     <= ST_DONE;
                        out_level <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    out_level <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    out_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: the driver expands the programmed table
// into the expected per-cycle output stream, the monitor compares what appears.
module tb_phase_sequencer;

    localparam int NPHASE = 4;
    localparam int AW     = 2;
    localparam int CW     = 8;

    logic          clk = 1'b0;
    logic          clr;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [CW-1:0] cfg_dur;
    logic          cfg_lvl;
    logic [AW-1:0] last_phase;
    logic          loop_en;
    logic          start;
    logic          abort;
    logic          busy;
    logic [AW-1:0] phase_idx;
    logic [CW-1:0] count;
    logic          out_level;
    logic          phase_tick;
    logic          done;

    always #5 clk = ~clk;

    phase_sequencer #(
        .NPHASE (NPHASE),
        .AW     (AW),
        .CW     (CW)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_dur    (cfg_dur),
        .cfg_lvl    (cfg_lvl),
        .last_phase (last_phase),
        .loop_en    (loop_en),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .phase_idx  (phase_idx),
        .count      (count),
        .out_level  (out_level),
        .phase_tick (phase_tick),
        .done       (done)
    );

    typedef struct packed {
        logic          busy;
        logic [AW-1:0] idx;
        logic [CW-1:0] cnt;
        logic          lvl;
        logic          tick;
        logic          done;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_dur [NPHASE];
    bit   m_lvl [NPHASE];
    bit   mon_on = 1'b0;

    task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    endtask

    // Monitor: every cycle in which the DUT presents activity consumes one expected entry.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [13:0] act;
        logic [13:0] req;
        if (mon_on) begin
            act = {busy, phase_idx, count, out_level, phase_tick, done};
            if (busy || done) begin
                if (expq.size() == 0) begin
                    check("unexpected_activity", 1'b0, 32'(act), 32'(0));
                end else begin
                    e = expq.pop_front();
                    req = e;
                    if (e.done)
                        check("done_cycle", {busy, out_level, phase_tick, done} == 4'b0001,
                              32'({busy, out_level, phase_tick, done}), 32'(4'b0001));
                    else
                        check("run_cycle", act == req, 32'(act), 32'(req));
                end
            end else begin
                check("idle_outputs", {out_level, phase_tick} == 2'b00,
                      32'({out_level, phase_tick}), 32'(0));
            end
        end
    end

    task automatic write_entry(input int a, input int d, input bit l);
        cfg_we   = 1'b1;
        cfg_addr = AW'(a);
        cfg_dur  = CW'(d);
        cfg_lvl  = l;
        @(posedge clk); #1;
        cfg_we   = 1'b0;
        m_dur[a] = d;
        m_lvl[a] = l;
    endtask

    // One pass through phases 0..lp: each phase contributes dur+1 cycles at its level.
    task automatic push_pass(input int lp);
        exp_t e;
        for (int p = 0; p <= lp; p++) begin
            for (int c = 0; c <= m_dur[p]; c++) begin
                e.busy = 1'b1;
                e.idx  = AW'(p);
                e.cnt  = CW'(c);
                e.lvl  = m_lvl[p];
                e.tick = (c == m_dur[p]);
                e.done = 1'b0;
                expq.push_back(e);
            end
        end
    endtask

    task automatic push_done();
        exp_t e;
        e      = '0;
        e.done = 1'b1;
        expq.push_back(e);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {busy, phase_idx, count, out_level, phase_tick, done} == '0,
              32'({busy, phase_idx, count, out_level, phase_tick, done}), 32'(0));
    endtask

    // Launch a sequence; abort_at>0 aborts during that run cycle (1-based), noise injects ignored inputs.
    task automatic run_seq(input int lp, input bit lpe, input int abort_at, input bit noise);
        int L;
        bit do_abort;
        int ncyc;
        L = 0;
        for (int p = 0; p <= lp; p++) L += m_dur[p] + 1;
        do_abort = (abort_at > 0) && (lpe || abort_at <= L);
        if (lpe) begin
            while (expq.size() < abort_at + 2) push_pass(lp);
        end else begin
            push_pass(lp);
            push_done();
        end
        last_phase = AW'(lp);
        loop_en    = lpe;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        last_phase = AW'($urandom);
        loop_en    = 1'($urandom);
        ncyc = do_abort ? abort_at : L + 1;
        for (int c = 1; c <= ncyc; c++) begin
            if (noise) begin
                start    = 1'($urandom);
                cfg_we   = 1'($urandom) | (c == 1);
                cfg_addr = (c == 1) ? AW'(0) : AW'($urandom);
                cfg_dur  = (c == 1) ? CW'(7) : CW'($urandom);
                cfg_lvl  = 1'($urandom);
            end
            if (do_abort && c == ncyc) abort = 1'b1;
            @(posedge clk); #1;
            start  = 1'b0;
            cfg_we = 1'b0;
            abort  = 1'b0;
        end
        if (do_abort) expq.delete();
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("drain", expq.size() == 0, 32'(expq.size()), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_dur = '0; cfg_lvl = 1'b0;
        last_phase = '0; loop_en = 1'b0; start = 1'b0; abort = 1'b0;
        for (int i = 0; i < NPHASE; i++) begin m_dur[i] = 0; m_lvl[i] = 1'b0; end
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        check_all_zero("reset_state");
        mon_on = 1'b1;

        // basic sequence: expected out_level 1,1,1,0,1,1 then done
        write_entry(0, 2, 1'b1);
        write_entry(1, 0, 1'b0);
        write_entry(2, 1, 1'b1);
        write_entry(3, 0, 1'b0);
        run_seq(2, 1'b0, 0, 1'b0);

        // looping sequence aborted in cycle 14
        run_seq(2, 1'b1, 14, 1'b0);

        // ignored cfg writes / start pulses during RUN, then re-run shows original table
        run_seq(2, 1'b0, 0, 1'b1);
        run_seq(2, 1'b0, 0, 1'b0);

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        check("start_abort_idle", {busy, done} == 2'b00, 32'({busy, done}), 32'(0));

        // boundary durations: 256-cycle phase then 1-cycle phase
        write_entry(0, 255, 1'b1);
        write_entry(1, 0, 1'b0);
        run_seq(1, 1'b0, 0, 1'b0);

        // clr in the middle of a looping run clears everything including the table
        write_entry(0, 2, 1'b1);
        write_entry(1, 0, 1'b1);
        last_phase = AW'(1); loop_en = 1'b1; start = 1'b1;
        push_pass(1);
        push_pass(1);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        expq.delete();
        for (int i = 0; i < NPHASE; i++) begin m_dur[i] = 0; m_lvl[i] = 1'b0; end
        check_all_zero("clr_mid_run");
        run_seq(0, 1'b0, 0, 1'b0);

        // randomized sequences
        for (int it = 0; it < 40; it++) begin
            int lp;
            bit lpe;
            int ab;
            for (int a = 0; a < NPHASE; a++)
                write_entry(a, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 6), 1'($urandom));
            lp  = $urandom_range(0, NPHASE - 1);
            lpe = 1'($urandom);
            if (lpe) ab = $urandom_range(1, 40);
            else     ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
            run_seq(lp, lpe, ab, 1'($urandom));
        end

        mon_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Programmable multi-phase timer controller that sequences an 8-bit terminal-count counter through a table of up to NPHASE phases.
- Each phase has its own duration and output level.
- Drives one output waveform (out_level) and per-phase terminal-count ticks.
- Used wherever the 8-bit modulo counter must run a sequence of different terminal counts rather than one fixed count, e.g. pulse trains and PWM-like patterns.

Parameters:
- NPHASE, 4, number of table entries (power of two, 2..16)
- AW, 2, phase index width = log2(NPHASE)
- CW, 8, counter/duration width

Ports:
- clk  in  1  single system clock, all logic on rising edge
- clr  in  1  synchronous, active-high reset
- cfg_we  in  1  table write strobe; honoured only in IDLE
- cfg_addr  in  AW  table entry to write
- cfg_dur  in  CW  phase duration value D (phase lasts D+1 cycles)
- cfg_lvl  in  1  out_level during that phase
- last_phase  in  AW  index of final phase; sampled on accepted start
- loop_en  in  1  sampled on accepted start; 1 = wrap from last_phase to phase 0 indefinitely
- start  in  1  begin sequence (single-cycle strobe, level tolerated)
- abort  in  1  stop sequence immediately
- busy  out  1  1 while in RUN
- phase_idx  out  AW  current phase index
- count  out  CW  current in-phase count
- out_level  out  1  registered waveform output
- phase_tick  out  1  combinational; 1 in the last cycle of a phase (count == dur[phase_idx]) while in RUN
- done  out  1  one-cycle pulse after a non-looping sequence completes

Behaviour:
- Reset: clr=1 at a clock edge clears state to IDLE, all table entries (dur=0, lvl=0), phase_idx=0, count=0, out_level=0, done=0, sampled last_phase/loop_en=0. busy=0 and phase_tick=0 follow.
- States: IDLE, RUN, DONE.
- IDLE:
  - cfg_we writes entry cfg_addr; readable by the sequence starting on the next cycle or later.
  - start=1 and abort=0 → RUN next cycle; sample last_phase and loop_en; phase_idx=0; count=0.
  - start and abort together in IDLE → abort wins; stay IDLE.
- RUN, each cycle:
  - If count != dur[phase_idx]: count+1.
  - Else (phase_tick=1), if phase_idx != last_phase_s: phase_idx+1 and count=0.
  - Else, if loop_en_s: phase_idx=0 and count=0.
  - Else: → DONE.
- Phase length is exactly dur+1 cycles. dur=0 gives a 1-cycle phase. dur=255 gives 256 cycles; count never wraps past dur.
- out_level is registered: it equals lvl[phase_idx] in every RUN cycle and is 0 in IDLE and DONE. The registers are loaded on the same edge as the state/phase update.
- Latency: start sampled at edge t → busy=1, out_level=lvl[0] from t+1.
- DONE: lasts 1 cycle with done=1, busy=0, out_level=0; then IDLE. start during DONE is ignored.
- abort=1 in RUN or DONE → IDLE next cycle; out_level=0; done not asserted; table preserved.
- start in RUN is ignored; the sequence is not restarted.
- cfg_we in RUN or DONE is dropped; the table is unchanged.
- Mid-operation clr behaves identically to reset: the table is also cleared.
- last_phase and loop_en changes during RUN have no effect (sampled copies are used).

Decomposition:
- Shared package holds:
  - state encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - default CW=8
- One natural sub-module: phase_counter.
  - CW-bit counter with synchronous clear, enable and terminal-compare input.
  - Produces the tick (count == compare).
  - Clears itself on tick when enabled.
- The FSM, table registers and out_level register stay in phase_sequencer.

Test Plan:
- Basic sequence:
  - Stimulus: reset, write dur={2,0,1,x}, lvl={1,0,1,x}, last_phase=2, loop_en=0, pulse start.
  - Response: out_level = 1,1,1,0,1,1 over 6 cycles with busy=1; phase_tick high on cycles 3,4,6; done=1 on cycle 7; then IDLE, out_level=0.
- Loop:
  - Stimulus: same table, loop_en=1, run 20 cycles.
  - Response: 6-cycle pattern repeats; phase_idx wraps 2→0; done never asserted; abort at cycle 14 gives busy=0 and out_level=0 from cycle 15.
- Boundary durations:
  - Stimulus: dur[0]=255, dur[1]=0, last_phase=1.
  - Response: phase 0 lasts 256 cycles, count reaches 255 then goes to 0; phase 1 lasts 1 cycle; done on cycle 258.
- Ignored inputs:
  - Stimulus: during RUN, cfg_we to entry 0 with dur=7, plus start pulses.
  - Response: timing unchanged; readback via a second run shows the original dur[0].
- Simultaneous events:
  - Stimulus: start+abort in IDLE.
  - Response: stays IDLE, busy=0.
- Reset mid-operation:
  - Stimulus: clr=1 during RUN.
  - Response: next cycle IDLE, all outputs 0; a following start with last_phase=0 gives a single 1-cycle phase with lvl=0 (table cleared).
